// File: rtl/sr_latch_driver_pkg.sv
// Shared types and helpers for the SR latch driver.
package sr_latch_driver_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE_S = 2'd1,
    DRIVE_R = 2'd2,
    GAP     = 2'd3
  } state_t;

  // Flops in each input synchroniser chain
  localparam int SYNC_STAGES = 2;

  // Bits needed to hold values 0..max_val; never less than one bit
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// Synchroniser, debounce counter and rising-edge strobe for one raw request line.
module sr_debounce
  import sr_latch_driver_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stb
);

  localparam int CW = cnt_width(DB_CYCLES);
  // The DB_CYCLES-th consecutive mismatching sample is the one that flips the level
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  logic [CW-1:0]          db_cnt;
  logic                   level;
  logic                   level_d;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // Metastability chain on the asynchronous request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Count consecutive samples that disagree with the debounced level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else if (sync_bit == level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      level  <= sync_bit;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // One-cycle strobe on a 0->1 change of the debounced level; releases are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= 1'b0;
      stb     <= 1'b0;
    end else begin
      level_d <= level;
      stb     <= level & ~level_d;
    end
  end

endmodule

// File: rtl/sr_latch_driver.sv
// SR latch driver: conditions two raw request lines and issues mutually
// exclusive, fixed-width S/R drive pulses separated by a recovery gap.
// Optional build macro SR_LATCH_DRIVER_SHADOW_EN adds q_shadow and skips
// pulses that would not change the latch.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | outputs inactive, arbitrating pending requests (R wins)
// DRIVE_S | S active, timer counts down the pulse width
// DRIVE_R | R active, timer counts down the pulse width
// GAP     | both inactive, timer counts down the recovery gap
module sr_latch_driver
  import sr_latch_driver_pkg::*;
#(
  parameter int DB_CYCLES    = 16,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic rst_req,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict
`ifdef SR_LATCH_DRIVER_SHADOW_EN
  ,
  output logic q_shadow
`endif
);

  localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = cnt_width(TMAX);

  // Timers load N-1 and terminate at zero, giving exactly N cycles
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  localparam logic OUT_OFF = ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic OUT_ON  = ~OUT_OFF;

  state_t          state;
  logic [TW-1:0]   timer;
  logic            pending_s;
  logic            pending_r;
  logic            set_stb;
  logic            rst_stb;
  logic            want_s;
  logic            want_r;
  logic            need_s;
  logic            need_r;

  sr_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db_set (
    .clk (clk),
    .rst (rst),
    .raw (set_req),
    .stb (set_stb)
  );

  sr_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db_rst (
    .clk (clk),
    .rst (rst),
    .raw (rst_req),
    .stb (rst_stb)
  );

  // Requests visible this cycle (a strobe counts even before it lands in its flag),
  // and which of them would actually move the latch
  always_comb begin
    want_s = pending_s | set_stb;
    want_r = pending_r | rst_stb;
`ifdef SR_LATCH_DRIVER_SHADOW_EN
    need_s = want_s & ~q_shadow;
    need_r = want_r &  q_shadow;
`else
    need_s = want_s;
    need_r = want_r;
`endif
  end

  // Sequencer with registered drive, busy and conflict outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      pending_s <= 1'b0;
      pending_r <= 1'b0;
      S         <= OUT_OFF;
      R         <= OUT_OFF;
      busy      <= 1'b0;
      conflict  <= 1'b0;
`ifdef SR_LATCH_DRIVER_SHADOW_EN
      q_shadow  <= 1'b0;
`endif
    end else begin
      conflict <= 1'b0;
      case (state)
        IDLE: begin
          // Everything pending is resolved here: driven, dropped or absorbed
          pending_s <= 1'b0;
          pending_r <= 1'b0;
          if (need_r) begin
            state    <= DRIVE_R;
            R        <= OUT_ON;
            busy     <= 1'b1;
            timer    <= PULSE_LOAD;
            conflict <= want_s;
          end else if (need_s) begin
            state <= DRIVE_S;
            S     <= OUT_ON;
            busy  <= 1'b1;
            timer <= PULSE_LOAD;
          end
        end
        DRIVE_S, DRIVE_R: begin
          pending_s <= pending_s | set_stb;
          pending_r <= pending_r | rst_stb;
          if (timer == '0) begin
            S <= OUT_OFF;
            R <= OUT_OFF;
`ifdef SR_LATCH_DRIVER_SHADOW_EN
            q_shadow <= (state == DRIVE_S);
`endif
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= GAP;
              timer <= GAP_LOAD;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        GAP: begin
          pending_s <= pending_s | set_stb;
          pending_r <= pending_r | rst_stb;
          if (timer == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          S     <= OUT_OFF;
          R     <= OUT_OFF;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Upstream control stage for the cross-coupled NAND SR latch.
- Takes two raw, asynchronous, bouncy request inputs (set and reset button/switch lines). Synchronises and debounces each one.
- Converts each qualified rising edge into a single fixed-width drive pulse on the latch S or R input.
- Guarantees S and R are never asserted together (the forbidden latch state). Enforces a recovery gap between pulses.

Parameters:
- DB_CYCLES, 16: consecutive stable synchronised samples required before a debounced level changes; legal range 1..65535.
- PULSE_CYCLES, 4: S/R drive pulse width in clk cycles; legal range 1..255.
- GAP_CYCLES, 2: cycles both outputs held inactive after a pulse before the next pulse may start; legal range 0..255.
- ACTIVE_LOW, 1: 1 = outputs idle high, assert low (NAND latch); 0 = idle low, assert high (NOR latch).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- set_req  input  1  raw asynchronous set request.
- rst_req  input  1  raw asynchronous reset request.
- S  output  1  latch set drive, polarity per ACTIVE_LOW.
- R  output  1  latch reset drive, polarity per ACTIVE_LOW.
- busy  output  1  high in DRIVE_S, DRIVE_R, GAP.
- conflict  output  1  one-cycle pulse when a set request is dropped because of a simultaneous reset request.

Behaviour:
- Reset (async assert, sync release) clears:
  - synchronisers and debounced levels to 0;
  - counters to 0; state to IDLE;
  - busy=0, conflict=0;
  - S=R=inactive level (1 when ACTIVE_LOW=1).
- Input conditioning, per input:
  - 2-flop synchroniser feeds the debounce counter.
  - Counter increments while sync != debounced level; clears when they are equal.
  - On reaching DB_CYCLES, the debounced level takes the sync value and the counter clears.
- Edge detect: a 0->1 transition of a debounced level sets a one-cycle request strobe (set_stb / rst_stb).
- Pending flags:
  - A strobe sets pending_s or pending_r. Flags hold while busy; requests are never lost.
  - A repeat strobe while its flag is already set merges (no queue depth >1 per input).
- Arbitration in IDLE:
  - pending_r wins over pending_s.
  - If both are pending in the same IDLE cycle: pending_s is cleared, conflict pulses for one cycle, and R is driven.
- FSM states:
  - IDLE: S,R inactive. pending_r -> DRIVE_R; else pending_s -> DRIVE_S. Entering a drive state clears its flag and loads the counter.
  - DRIVE_S: S active for exactly PULSE_CYCLES cycles, then GAP (or IDLE if GAP_CYCLES=0).
  - DRIVE_R: as DRIVE_S, driving R.
  - GAP: both inactive for exactly GAP_CYCLES cycles, then IDLE.
- Latency:
  - Request to pulse start = 2 sync + DB_CYCLES + 1 edge + 1 FSM register.
  - The first active S/R cycle is the cycle after the state register enters DRIVE_x.
- Output and width rules:
  - S and R are registered outputs, glitch-free. Invariant: S and R are never simultaneously active in any cycle.
  - Counter widths come from $clog2(max+1) of their parameter; no wrap. Counters saturate-compare with ==.
- Boundary conditions:
  - A bounce shorter than DB_CYCLES is ignored.
  - Request release (1->0) generates nothing.
  - rst asserted mid-pulse forces S/R inactive immediately (asynchronous) and discards pending flags.

Optional Feature:
- Macro: SR_LATCH_DRIVER_SHADOW_EN.
- When defined:
  - Adds output q_shadow (1 bit, reset 0) tracking the expected latch Q: set at the end of DRIVE_S, cleared at the end of DRIVE_R.
  - A pending set while q_shadow=1 (or pending reset while q_shadow=0) is cleared in IDLE without any pulse, busy or gap.
- When undefined: no q_shadow port; every qualified request produces a pulse.

Decomposition:
- Package sr_latch_driver_pkg:
  - state enum: IDLE, DRIVE_S, DRIVE_R, GAP;
  - localparam for synchroniser depth (2);
  - a function returning counter width.
- Sub-module sr_debounce (synchroniser + debounce counter + rising-edge strobe), instantiated twice.
- FSM and output registers stay in the top.

Test Plan (defaults, ACTIVE_LOW=1):
- Reset: assert rst mid-DRIVE_S -> S=R=1 and busy=0 within the same cycle; no pulse resumes after release.
- Clean set:
  - Stimulus: set_req held high 40 cycles.
  - Response: exactly one S low pulse of 4 cycles starting 20 cycles after the edge, then R=1; 2-cycle gap, busy high 6 cycles.
- Bounce rejection: set_req toggles every 5 cycles for 60 cycles then returns low -> no S pulse, busy stays 0.
- Simultaneous: set_req and rst_req rise on the same clk -> conflict=1 for one cycle, one R pulse of 4 cycles, no S pulse.
- Back-to-back: rst_req edge qualifies while DRIVE_S is active -> S pulse completes, 2-cycle gap, then R pulse. Assert S and R are never low together throughout.
- Shadow (SR_LATCH_DRIVER_SHADOW_EN):
  - Two separate set requests -> one S pulse, q_shadow=1, second request absorbed with busy=0.
  - A reset request then yields an R pulse and q_shadow=0.
